// File: rtl/alarm_fsm.sv
// alarm_fsm: alarm clock main controller (keypad entry, alarm/time loads).
// Optional macro ALARM_FSM_DIGIT_LIMIT_EN caps entry at four digits.
module alarm_fsm #(
   parameter int unsigned TIMEOUT_SECS = 10,
   parameter logic [3:0]  NOKEY        = 4'hA
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       one_second,
   input  logic [3:0] key,
   input  logic       alarm_button,
   input  logic       time_button,
   output logic       shift,
   output logic       show_new_time,
   output logic       show_a,
   output logic       load_new_a,
   output logic       load_new_c,
   output logic       reset_count
);

   localparam int unsigned CW = $clog2(TIMEOUT_SECS);

   typedef enum logic [2:0] {
      SHOW_TIME        = 3'd0,
      KEY_STORED       = 3'd1,
      KEY_WAITED       = 3'd2,
      KEY_ENTRY        = 3'd3,
      SHOW_ALARM       = 3'd4,
      SET_ALARM_TIME   = 3'd5,
      SET_CURRENT_TIME = 3'd6
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          shift_q, shift_d;
   logic          snt_q, snt_d;
   logic          sa_q, sa_d;
   logic          la_q, la_d;
   logic          lc_q, lc_d;
   logic          rc_q, rc_d;
   logic          key_hit;
   logic          timeout;
   logic          digits_full;

`ifdef ALARM_FSM_DIGIT_LIMIT_EN
   logic [2:0] dig_q, dig_d;

   // digit counter: restarts on every return to the idle display
   always_comb begin
      dig_d = dig_q;
      if (state_q == SHOW_TIME)
         dig_d = '0;
      else if (state_q == KEY_STORED)
         dig_d = dig_q + 3'd1;
   end

   assign digits_full = (dig_q >= 3'd4);

   // digit counter register
   always_ff @(posedge clock) begin
      if (!reset)
         dig_q <= '0;
      else
         dig_q <= dig_d;
   end
`else
   assign digits_full = 1'b0;
`endif

   assign key_hit = (key != NOKEY);
   assign timeout = one_second && (cnt_q == CW'(TIMEOUT_SECS - 1));

   // next state, inactivity counter and outputs decoded from next state
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      if (state_q == KEY_WAITED || state_q == KEY_ENTRY) begin
         if (timeout)
            cnt_d = '0;
         else if (one_second)
            cnt_d = cnt_q + 1'b1;
         else
            cnt_d = cnt_q;
      end
      unique case (state_q)
         SHOW_TIME: begin
            if (alarm_button)
               state_d = SHOW_ALARM;
            else if (key_hit)
               state_d = KEY_STORED;
         end
         KEY_STORED:
            state_d = KEY_WAITED;
         KEY_WAITED: begin
            if (!key_hit)
               state_d = KEY_ENTRY;
            else if (timeout)
               state_d = SHOW_TIME;
         end
         KEY_ENTRY: begin
            if (alarm_button)
               state_d = SET_ALARM_TIME;
            else if (time_button)
               state_d = SET_CURRENT_TIME;
            else if (key_hit && !digits_full)
               state_d = KEY_STORED;
            else if (timeout)
               state_d = SHOW_TIME;
         end
         SHOW_ALARM: begin
            if (!alarm_button)
               state_d = SHOW_TIME;
         end
         SET_ALARM_TIME:
            state_d = SHOW_TIME;
         SET_CURRENT_TIME:
            state_d = SHOW_TIME;
         default:
            state_d = SHOW_TIME;
      endcase
      shift_d = (state_d == KEY_STORED);
      snt_d   = (state_d == KEY_ENTRY);
      sa_d    = (state_d == SHOW_ALARM);
      la_d    = (state_d == SET_ALARM_TIME);
      lc_d    = (state_d == SET_CURRENT_TIME);
      rc_d    = (state_d == SET_CURRENT_TIME);
   end

   // state, counter and registered Moore outputs
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= SHOW_TIME;
         cnt_q   <= '0;
         shift_q <= 1'b0;
         snt_q   <= 1'b0;
         sa_q    <= 1'b0;
         la_q    <= 1'b0;
         lc_q    <= 1'b0;
         rc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         snt_q   <= snt_d;
         sa_q    <= sa_d;
         la_q    <= la_d;
         lc_q    <= lc_d;
         rc_q    <= rc_d;
      end
   end

   assign shift         = shift_q;
   assign show_new_time = snt_q;
   assign show_a        = sa_q;
   assign load_new_a    = la_q;
   assign load_new_c    = lc_q;
   assign reset_count   = rc_q;

endmodule
